// File: rtl/rv32m_unit.sv
// RISC-V M-extension execute unit: one-cycle multiply, 32-step restoring divide.
// READY pulses for a single cycle in DONE; OUT holds the last result otherwise.
module rv32m_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [2:0]  M_CNT,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    output logic [31:0] OUT,
    output logic        READY
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q;
    logic [31:0] out_q;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    logic [31:0] dmag_q, quo_q, rem_q;
    logic [4:0]  cnt_q;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? neg32(v) : v;
    endfunction

    logic        a_sgn, b_sgn;
    logic [63:0] a64, b64, prod;
    logic [31:0] mul_res;

    always_comb begin
        a_sgn   = (op_q[1:0] != 2'b11);
        b_sgn   = (op_q[1:0] == 2'b01);
        a64     = {{32{a_sgn & a_q[31]}}, a_q};
        b64     = {{32{b_sgn & b_q[31]}}, b_q};
        prod    = a64 * b64;
        mul_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end

    logic        div_signed, div_zero, div_ovf, ge;
    logic [32:0] r_sh;
    logic [31:0] rem_d, quo_d, q_fix, r_fix, div_res, spec_res;

    always_comb begin
        div_signed = ~op_q[0];
        div_zero   = (b_q == 32'd0);
        div_ovf    = div_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        // Restoring step: shift in next dividend bit, subtract divisor if it fits.
        r_sh  = {rem_q, quo_q[31]};
        ge    = (r_sh >= {1'b0, dmag_q});
        rem_d = ge ? (r_sh[31:0] - dmag_q) : r_sh[31:0];
        quo_d = {quo_q[30:0], ge};
        q_fix = (div_signed && (a_q[31] ^ b_q[31])) ? neg32(quo_d) : quo_d;
        r_fix = (div_signed && a_q[31]) ? neg32(rem_d) : rem_d;
        div_res  = op_q[1] ? r_fix : q_fix;
        spec_res = div_zero ? (op_q[1] ? a_q : 32'hFFFF_FFFF)
                            : (op_q[1] ? 32'd0 : 32'h8000_0000);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            out_q   <= 32'd0;
            cnt_q   <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        a_q     <= RS1;
                        b_q     <= RS2;
                        op_q    <= M_CNT;
                        quo_q   <= abs_if(RS1, ~M_CNT[0]);
                        dmag_q  <= abs_if(RS2, ~M_CNT[0]);
                        rem_q   <= 32'd0;
                        cnt_q   <= 5'd0;
                        state_q <= M_CNT[2] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    if (!START) begin
                        state_q <= S_IDLE;
                    end else begin
                        out_q   <= mul_res;
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (!START) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == 5'd0 && (div_zero || div_ovf)) begin
                        out_q   <= spec_res;
                        state_q <= S_DONE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            out_q   <= div_res;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign OUT   = out_q;
    assign READY = (state_q == S_DONE);

endmodule

// File: tb/tb_rv32m_unit.sv
// Directed vector bench for rv32m_unit: table of single operations plus
// hand-written abort, reset-mid-divide and back-to-back sequences.
module tb_rv32m_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [2:0]  M_CNT;
    logic [31:0] RS1, RS2;
    logic [31:0] OUT;
    logic        READY;

    int tests = 0;
    int fails = 0;

    rv32m_unit dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .M_CNT(M_CNT),
        .RS1  (RS1),
        .RS2  (RS2),
        .OUT  (OUT),
        .READY(READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one operation and measure edges until READY (START edge = 1).
    task automatic run_op(input vec_t v);
        int got;
        got   = 0;
        START = 1'b1;
        M_CNT = v.op;
        RS1   = v.a;
        RS2   = v.b;
        for (int e = 1; e <= 45; e++) begin
            tick();
            RS1 = $urandom;
            RS2 = $urandom;
            if (READY) begin
                got = e;
                break;
            end
        end
        START = 1'b0;
        check({v.name, " latency"}, got, v.lat);
        check({v.name, " value"}, OUT, v.exp);
        tick();
        check({v.name, " ready drop"}, {31'd0, READY}, 32'd0);
    endtask

    initial begin
        int          nrdy;
        logic [31:0] held;
        int          rdy_at[$];
        logic        prev_rdy;
        logic        dbl;

        vecs[0]  = '{"mul 7x6",       3'b000, 32'd7,         32'd6,         32'd42,        2};
        vecs[1]  = '{"mulh -1x-1",    3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  2};
        vecs[2]  = '{"mulhu max",     3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  2};
        vecs[3]  = '{"mulhsu -1xmax", 3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  2};
        vecs[4]  = '{"mul -1x-1",     3'b000, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  2};
        vecs[5]  = '{"mulh min^2",    3'b001, 32'h80000000,  32'h80000000,  32'h40000000,  2};
        vecs[6]  = '{"mulhu min x2",  3'b011, 32'h80000000,  32'd2,         32'h00000001,  2};
        vecs[7]  = '{"div -7/2",      3'b100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  33};
        vecs[8]  = '{"rem -7/2",      3'b110, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  33};
        vecs[9]  = '{"divu -7/2",     3'b101, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  33};
        vecs[10] = '{"remu -7/2",     3'b111, 32'hFFFFFFF9,  32'd2,         32'h00000001,  33};
        vecs[11] = '{"div ovf",       3'b100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  2};
        vecs[12] = '{"rem ovf",       3'b110, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  2};
        vecs[13] = '{"divu by 0",     3'b101, 32'd123,       32'd0,         32'hFFFFFFFF,  2};
        vecs[14] = '{"remu by 0",     3'b111, 32'd123,       32'd0,         32'd123,       2};
        vecs[15] = '{"div 100/-3",    3'b100, 32'd100,       32'hFFFFFFFD,  32'hFFFFFFDF,  33};
        vecs[16] = '{"rem 100/-3",    3'b110, 32'd100,       32'hFFFFFFFD,  32'h00000001,  33};
        vecs[17] = '{"rem -100/3",    3'b110, 32'hFFFFFF9C,  32'd3,         32'hFFFFFFFF,  33};
        vecs[18] = '{"div -5/0",      3'b100, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  2};
        vecs[19] = '{"rem -5/0",      3'b110, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  2};
        vecs[20] = '{"divu max/1",    3'b101, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  33};
        vecs[21] = '{"divu 100/3",    3'b101, 32'd100,       32'd3,         32'd33,        33};

        RST = 1'b1; START = 1'b0; M_CNT = 3'b000; RS1 = '0; RS2 = '0;
        tick();
        check("reset out", OUT, 32'd0);
        check("reset ready", {31'd0, READY}, 32'd0);
        RST = 1'b0;
        tick();

        foreach (vecs[i]) run_op(vecs[i]);

        // Abort mid-divide: no pulse, OUT keeps the previous result (33).
        held  = 32'd33;
        START = 1'b1; M_CNT = 3'b101; RS1 = 32'd100; RS2 = 32'd3;
        nrdy  = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (READY) nrdy++;
        end
        START = 1'b0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (READY) nrdy++;
        end
        check("abort no ready", nrdy, 0);
        check("abort out held", OUT, held);

        // Reset mid-divide.
        START = 1'b1;
        nrdy  = 0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (READY) nrdy++;
        end
        RST = 1'b1; START = 1'b0;
        tick();
        check("rst mid out", OUT, 32'd0);
        check("rst mid ready", {31'd0, READY}, 32'd0);
        RST = 1'b0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (READY) nrdy++;
        end
        check("rst mid no ready", nrdy, 0);
        check("rst mid out stays", OUT, 32'd0);

        // Back-to-back with START held high.
        START = 1'b1; M_CNT = 3'b000; RS1 = 32'd3; RS2 = 32'd5;
        prev_rdy = 1'b0;
        dbl      = 1'b0;
        for (int e = 1; e <= 60 && rdy_at.size() < 2; e++) begin
            tick();
            if (READY && prev_rdy) dbl = 1'b1;
            prev_rdy = READY;
            if (READY) begin
                rdy_at.push_back(e);
                if (rdy_at.size() == 1) begin
                    check("b2b mul value", OUT, 32'd15);
                    M_CNT = 3'b101; RS1 = 32'd20; RS2 = 32'd4;
                end else begin
                    check("b2b divu value", OUT, 32'd5);
                end
            end
        end
        START = 1'b0;
        tick();
        if (READY && prev_rdy) dbl = 1'b1;
        check("b2b ready count", rdy_at.size(), 2);
        if (rdy_at.size() == 2) begin
            check("b2b first ready edge", rdy_at[0], 2);
            check("b2b second ready edge", rdy_at[1], 36);
        end
        check("b2b no double ready", {31'd0, dbl}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32m_unit.md
Name: rv32m_unit

Overview:
- Multi-cycle execution unit for the RISC-V M extension: multiply, multiply-high, divide and remainder on 32-bit operands.
- Sits beside the ALU in the execute stage.
- The stage holds START high while an M-type instruction is in EX, and stalls the pipeline while START is high and READY is low.
- The result on OUT is selected by the ALU result mux when READY is high.

Parameters:
None.

Ports:
CLK    input   1   rising-edge clock
RST    input   1   synchronous active-high reset
START  input   1   level request; high while an M instruction occupies EX and is not flushed
M_CNT  input   3   operation select, RISC-V funct3 encoding
RS1    input   32  first source operand (rs1; dividend / multiplicand)
RS2    input   32  second source operand (rs2; divisor / multiplier)
OUT    output  32  result register
READY  output  1   result valid; one-cycle pulse

Behaviour:
- M_CNT encoding:
  - 000 MUL: low 32 bits of the product
  - 001 MULH: high 32 bits, signed x signed
  - 010 MULHSU: high 32 bits, signed RS1 x unsigned RS2
  - 011 MULHU: high 32 bits, unsigned x unsigned
  - 100 DIV: signed quotient
  - 101 DIVU: unsigned quotient
  - 110 REM: signed remainder
  - 111 REMU: unsigned remainder
- States: IDLE, MUL, DIV, DONE.
- Reset: state IDLE, OUT=0, READY=0, iteration counter=0.
  - Reset has priority over everything, including mid-operation; any in-flight operation is discarded.
- READY is combinational: high only in DONE. OUT holds its last value in all other states.
- IDLE with START=1 at a clock edge:
  - Latch RS1, RS2 and M_CNT.
  - M_CNT[2]=0: go to MUL.
  - M_CNT[2]=1: go to DIV.
  - Operands may change after latching; only latched copies are used.
- MUL (one cycle):
  - At the next edge, compute the full 64-bit product with per-op sign extension.
  - Write the selected half to OUT, then go to DONE.
  - READY is high in the 2nd cycle after the START-sampling edge, i.e. multiply latency is 2 edges.
- DIV:
  - Special cases are resolved at the first edge, then go to DONE (same latency as multiply):
    - Divisor 0: quotient = 0xFFFFFFFF; remainder = dividend.
    - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
  - Otherwise: radix-2 restoring division of the operand magnitudes, one quotient bit per edge, 32 edges.
  - After that, apply signs:
    - Quotient is negated if the operand signs differ (signed ops only).
    - Remainder takes the dividend's sign.
  - Write OUT, go to DONE. READY appears after 33 edges from the START-sampling edge.
- DONE: READY=1 for exactly one cycle, then go to IDLE unconditionally.
  - A new operation can be sampled in the following IDLE cycle if START is still or again high, so back-to-back M instructions each get a fresh computation.
- Abort: if START=0 at an edge while in MUL or DIV, return to IDLE.
  - OUT is not updated and no READY pulse is produced.
  - This handles pipeline flushes.
- START=0 in IDLE: remain IDLE.
- Arithmetic is pure two's complement on 32-bit values. No exceptions or traps are raised.

Test Plan:
1. Reset then multiply: RST=1 for one edge → OUT=0, READY=0. Then START=1, M_CNT=000, RS1=7, RS2=6 → READY high exactly 2 cycles later with OUT=42, then READY=0.
2. Multiply-high variants with RS1=0xFFFFFFFF, RS2=0xFFFFFFFF:
   - MULH → OUT=0x00000000
   - MULHU → OUT=0xFFFFFFFE
   - MULHSU → OUT=0xFFFFFFFF
   - MUL → OUT=0x00000001
3. Signed divide/remainder with RS1=-7 (0xFFFFFFF9), RS2=2, READY after 33 edges:
   - DIV → OUT=0xFFFFFFFD (-3)
   - REM → OUT=0xFFFFFFFF (-1)
   - DIVU → OUT=0x7FFFFFFC
   - REMU → OUT=1
4. Corner cases, each with READY after 2 edges:
   - RS1=0x80000000, RS2=0xFFFFFFFF: DIV → 0x80000000; REM → 0.
   - RS1=123, RS2=0: DIVU → 0xFFFFFFFF; REMU → 123.
5. Abort and reset mid-divide:
   - Start DIVU 100/3, drop START after 10 edges → no READY pulse; OUT unchanged.
   - Restart the same op, assert RST after 5 edges → IDLE, OUT=0, no READY.
6. Back-to-back operations: hold START=1 continuously, switching operands and M_CNT right after the READY pulse (MUL 3×5, then DIVU 20/4) → first READY with OUT=15, second READY 33 edges after its IDLE sampling edge with OUT=5; READY is never high for two consecutive cycles.
